instruction_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 75 +++++++
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: PC selector codes (also used by the program
// counter) and the fetch FSM state encoding.
package fetch_pkg;

  localparam logic [1:0] SELECTOR_NEXT_INSTRUCTION = 2'd0;
  localparam logic [1:0] SELECTOR_KEEP_INSTRUCTION = 2'd1;
  localparam logic [1:0] SELECTOR_LOAD_INSTRUCTION = 2'd2;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {instruction, pc} pairs between program memory and decode.
// DEPTH is 1 or 2; entry 0 is the head. flush empties the FIFO and wins over
// a same-cycle push or pop.
module fetch_buffer #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned WORD_SIZE   = 15,
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic [INSTR_WIDTH-1:0]         push_instr,
  input  logic [WORD_SIZE-1:0]           push_pc,
  input  logic                           pop,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [INSTR_WIDTH-1:0]         head_instr,
  output logic [WORD_SIZE-1:0]           head_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_d [DEPTH];
  logic [WORD_SIZE-1:0]   pc_q    [DEPTH];
  logic [WORD_SIZE-1:0]   pc_d    [DEPTH];
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic [CW-1:0]          base;

  // Next contents: shift out the head on pop, then append at the new tail.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    base    = count_q;
    if (pop && (count_q != '0)) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        instr_d[i] = instr_q[i+1];
        pc_d[i]    = pc_q[i+1];
      end
      base = count_q - 1'b1;
    end
    count_d = base;
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == base) begin
          instr_d[i] = push_instr;
          pc_d[i]    = push_pc;
        end
      end
      count_d = base + 1'b1;
    end
    if (flush) count_d = '0;
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign count      = count_q;
  assign head_instr = instr_q[0];
  assign head_pc    = pc_q[0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: steers the program counter, reads synchronous program memory
// at the current PC and presents fetched instructions to decode over a
// valid/ready handshake. A redirect from execute flushes everything in flight.
// Optional macro FETCH_SKID_EN: 2-entry skid buffer for full throughput;
// undefined builds use a single output register (one instruction per 2 cycles).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 15,
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WORD_SIZE-1:0]   pc,
  output logic [1:0]             pc_selector,
  output logic [WORD_SIZE-1:0]   pc_load_value,
  output logic                   mem_read,
  output logic [WORD_SIZE-1:0]   mem_address,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   redirect,
  input  logic [WORD_SIZE-1:0]   redirect_target,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [WORD_SIZE-1:0]   instr_pc
);

`ifdef FETCH_SKID_EN
  localparam int unsigned SLOTS = 2;
`else
  localparam int unsigned SLOTS = 1;
`endif
  localparam int unsigned CW = $clog2(SLOTS + 1);

  fetch_state_t         state_q;
  fetch_state_t         state_d;
  logic                 issue;
  logic                 transfer;
  logic [2:0]           occupancy;
  logic                 outstanding_q;
  logic [WORD_SIZE-1:0] outstanding_pc_q;
  logic [CW-1:0]        buf_count;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH_BOOT;
    else       state_q <= state_d;
  end

  // FSM next state: BOOT is a single idle cycle, RUN is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN:  state_d = FETCH_RUN;
      default:    state_d = FETCH_BOOT;
    endcase
  end

  assign transfer = instr_valid && instr_ready;
  // A slot being drained this cycle can be refilled by this cycle's issue.
  assign occupancy = 3'(buf_count) + 3'(outstanding_q) - 3'(transfer);

  // FSM outputs: redirect beats issue; issue only while slots remain.
  always_comb begin
    issue       = 1'b0;
    mem_read    = 1'b0;
    pc_selector = SELECTOR_KEEP_INSTRUCTION;
    if (reset) begin
      pc_selector = SELECTOR_KEEP_INSTRUCTION;
    end else if (redirect) begin
      pc_selector = SELECTOR_LOAD_INSTRUCTION;
    end else if ((state_q == FETCH_RUN) && (occupancy < 3'(SLOTS))) begin
      issue       = 1'b1;
      mem_read    = 1'b1;
      pc_selector = SELECTOR_NEXT_INSTRUCTION;
    end
  end

  assign pc_load_value = redirect_target;
  assign mem_address   = pc;

  // Outstanding read tag; a redirect drops its returning data.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding_q    <= 1'b0;
      outstanding_pc_q <= '0;
    end else begin
      outstanding_q <= issue;
      if (issue) outstanding_pc_q <= pc;
    end
  end

  fetch_buffer #(
    .DEPTH       (SLOTS),
    .WORD_SIZE   (WORD_SIZE),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect),
    .push       (outstanding_q && !redirect),
    .push_instr (mem_data),
    .push_pc    (outstanding_pc_q),
    .pop        (transfer),
    .count      (buf_count),
    .head_instr (instr_out),
    .head_pc    (instr_pc)
  );

  assign instr_valid = (buf_count != '0);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small PC and program-memory
// environment. Memory content is M[a] = a ^ 16'h5A5A.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] pc;
  logic [1:0]  pc_selector;
  logic [14:0] pc_load_value;
  logic        mem_read;
  logic [14:0] mem_address;
  logic [15:0] mem_data;
  logic        redirect;
  logic [14:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [14:0] instr_pc;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [14:0] exp_pc;

  instruction_fetch #(.WORD_SIZE(15), .INSTR_WIDTH(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .pc_selector     (pc_selector),
    .pc_load_value   (pc_load_value),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc)
  );

  always #5 clock = ~clock;

  // Program counter and synchronous memory environment.
  always @(posedge clock) begin
    if (reset) pc <= '0;
    else case (pc_selector)
      2'd0:    pc <= pc + 15'd1;
      2'd2:    pc <= pc_load_value;
      default: pc <= pc;
    endcase
    mem_data <= mem_read ? ({1'b0, mem_address} ^ 16'h5A5A) : 16'hDEAD;
  end

  task automatic test_reset();
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (pc_selector !== 2'd1) begin n_fail++; $display("FAIL rst_sel: got %0d want 1", pc_selector); end
    reset = 1'b0; #1;
    n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL boot_read: got %b want 0", mem_read); end
    n_cmp++; if (pc_selector !== 2'd1) begin n_fail++; $display("FAIL boot_sel: got %0d want 1", pc_selector); end
    @(negedge clock);
    n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL c1_read: got %b want 1", mem_read); end
    n_cmp++; if (mem_address !== 15'h0000) begin n_fail++; $display("FAIL c1_addr: got %h want 0000", mem_address); end
    n_cmp++; if (pc_selector !== 2'd0) begin n_fail++; $display("FAIL c1_sel: got %0d want 0", pc_selector); end
    @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL c2_valid: got %b want 0", instr_valid); end
    @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL c3_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr_pc !== 15'h0000) begin n_fail++; $display("FAIL c3_pc: got %h want 0000", instr_pc); end
    n_cmp++; if (instr_out !== 16'h5A5A) begin n_fail++; $display("FAIL c3_data: got %h want 5A5A", instr_out); end
    exp_pc = 15'd1;
  endtask

  task automatic test_stream();
    int valids = 0;
    int exp_valids;
`ifdef FETCH_SKID_EN
    exp_valids = 12;
`else
    exp_valids = 6;
`endif
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        valids++;
        n_cmp++; if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc: got %h want %h", instr_pc, exp_pc); end
        n_cmp++; if (instr_out !== ({1'b0, exp_pc} ^ 16'h5A5A)) begin n_fail++; $display("FAIL stream_data: got %h want %h", instr_out, {1'b0, exp_pc} ^ 16'h5A5A); end
        exp_pc = exp_pc + 15'd1;
      end
    end
    n_cmp++; if (valids !== exp_valids) begin n_fail++; $display("FAIL stream_rate: got %0d want %0d", valids, exp_valids); end
  endtask

  task automatic test_backpressure();
    logic [15:0] held_out;
    logic [14:0] held_pc;
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (instr_valid) found = 1;
      else if (i == 9) begin n_cmp++; n_fail++; $display("FAIL bp_wait: got no valid want valid"); end
    end
    if (found) begin
      instr_ready = 1'b0;
      held_out = instr_out; held_pc = instr_pc;
      n_cmp++; if (held_pc !== exp_pc) begin n_fail++; $display("FAIL bp_head: got %h want %h", held_pc, exp_pc); end
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== held_pc || instr_out !== held_out) begin
          n_fail++; $display("FAIL bp_hold: got %b/%h/%h want 1/%h/%h", instr_valid, instr_pc, instr_out, held_pc, held_out);
        end
      end
      n_cmp++; if (pc_selector !== 2'd1) begin n_fail++; $display("FAIL bp_sel: got %0d want 1", pc_selector); end
      instr_ready = 1'b1;
      exp_pc = exp_pc + 15'd1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        if (instr_valid) begin
          n_cmp++; if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL bp_resume: got %h want %h", instr_pc, exp_pc); end
          exp_pc = exp_pc + 15'd1;
        end
      end
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (mem_read) found = 1;
    end
    if (!found) begin n_cmp++; n_fail++; $display("FAIL rd_wait: got no issue want issue"); end
    @(negedge clock);
    redirect = 1'b1; redirect_target = 15'h1234; #1;
    n_cmp++; if (pc_selector !== 2'd2) begin n_fail++; $display("FAIL rd_sel: got %0d want 2", pc_selector); end
    n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rd_read: got %b want 0", mem_read); end
    n_cmp++; if (pc_load_value !== 15'h1234) begin n_fail++; $display("FAIL rd_load: got %h want 1234", pc_load_value); end
    @(negedge clock);
    redirect = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush: got %b want 0", instr_valid); end
    n_cmp++; if (mem_read !== 1'b1 || mem_address !== 15'h1234) begin n_fail++; $display("FAIL rd_issue: got %b/%h want 1/1234", mem_read, mem_address); end
    @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_squash: got %b want 0", instr_valid); end
    @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 15'h1234 || instr_out !== 16'h486E) begin
      n_fail++; $display("FAIL rd_target: got %b/%h/%h want 1/1234/486E", instr_valid, instr_pc, instr_out);
    end
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        found = 1;
        n_cmp++; if (instr_pc !== 15'h1235 || instr_out !== 16'h486F) begin
          n_fail++; $display("FAIL rd_next: got %h/%h want 1235/486F", instr_pc, instr_out);
        end
      end
    end
    if (!found) begin n_cmp++; n_fail++; $display("FAIL rd_next_wait: got no valid want 1235"); end
  endtask

  task automatic test_wrap();
    logic [14:0] pcs [3];
    logic [15:0] dat [3];
    int got = 0;
    pcs[0] = 15'h7FFE; pcs[1] = 15'h7FFF; pcs[2] = 15'h0000;
    dat[0] = 16'h25A4; dat[1] = 16'h25A5; dat[2] = 16'h5A5A;
    @(negedge clock);
    redirect = 1'b1; redirect_target = 15'h7FFE;
    @(negedge clock);
    redirect = 1'b0;
    for (int i = 0; i < 12 && got < 3; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        n_cmp++; if (instr_pc !== pcs[got] || instr_out !== dat[got]) begin
          n_fail++; $display("FAIL wrap_%0d: got %h/%h want %h/%h", got, instr_pc, instr_out, pcs[got], dat[got]);
        end
        got++;
      end
    end
    if (got < 3) begin n_cmp++; n_fail++; $display("FAIL wrap_wait: got %0d want 3", got); end
  endtask

  task automatic test_reset_midstream();
    bit found = 0;
    redirect_target = '0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (instr_valid) found = 1;
    end
    if (!found) begin n_cmp++; n_fail++; $display("FAIL mrst_wait: got no valid want valid"); end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b0 || instr_out !== 16'h0000 || instr_pc !== 15'h0000) begin
      n_fail++; $display("FAIL mrst_out: got %b/%h/%h want 0/0000/0000", instr_valid, instr_out, instr_pc);
    end
    n_cmp++; if (mem_read !== 1'b0 || pc_selector !== 2'd1 || pc_load_value !== 15'h0000) begin
      n_fail++; $display("FAIL mrst_ctl: got %b/%0d/%h want 0/1/0000", mem_read, pc_selector, pc_load_value);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_c2: got %b want 0", instr_valid); end
    @(negedge clock);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 15'h0000 || instr_out !== 16'h5A5A) begin
      n_fail++; $display("FAIL mrst_first: got %b/%h/%h want 1/0000/5A5A", instr_valid, instr_pc, instr_out);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
